// File: rtl/int_ctrl_if.sv
// rtl/int_ctrl_if.sv - interrupt controller request/acknowledge bundle
interface int_ctrl_if;
  // Request side: raw interrupt lines, mask programming, next-PC handshake
  logic [3:0]  irq_in;
  logic        mask_we;
  logic [3:0]  mask_wdata;
  logic        int_ack;
  logic        int_ret;
  logic [31:0] epc_in;

  // Controller outputs
  logic        INT;
  logic [1:0]  INT_data;
  logic [31:0] epc;
  logic        in_service;
  logic [3:0]  pending;
  logic [3:0]  irq_mask;

  // The controller itself
  modport slave (
    input  irq_in, mask_we, mask_wdata, int_ack, int_ret, epc_in,
    output INT, INT_data, epc, in_service, pending, irq_mask
  );

  // The pipeline / environment that drives the controller
  modport master (
    output irq_in, mask_we, mask_wdata, int_ack, int_ret, epc_in,
    input  INT, INT_data, epc, in_service, pending, irq_mask
  );
endinterface

// File: rtl/int_ctrl.sv
// rtl/int_ctrl.sv - four-source edge-triggered interrupt controller with fixed priority
module int_ctrl #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [3:0] MASK_RESET  = 4'hF
) (
  input logic       clk,
  input logic       rst,
  int_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  // Synchronizer chain: stage 0 samples the raw pins, the last stage is the clean value
  logic [SYNC_STAGES-1:0][3:0] sync_q;
  logic [3:0]                  sync_d;
  logic [3:0]                  irq_sync;
  logic [3:0]                  irq_rise;

  logic [3:0]  pending_q;
  logic [3:0]  mask_q;
  logic [3:0]  eligible;
  logic [1:0]  pick_id;
  logic [3:0]  ack_clr;
  logic        ack_take;

  state_t      state;
  logic        int_q;
  logic [1:0]  int_data_q;
  logic [31:0] epc_q;
  logic        in_service_q;

  assign irq_sync = sync_q[SYNC_STAGES-1];
  // A rise is the clean value high while its one-cycle-old copy is low; a held
  // level therefore produces exactly one rise.
  assign irq_rise = irq_sync & ~sync_d;

  // Shift raw requests through the synchronizer and keep a delayed copy for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      sync_d <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.irq_in};
      sync_d <= irq_sync;
    end
  end

  // Masking only gates selection; pending still records masked sources
  assign eligible = pending_q & mask_q;

  // Lowest index wins: scan from the top so bit 0 is written last
  always_comb begin
    pick_id = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (eligible[i]) pick_id = 2'(i);
    end
  end

  // An acknowledge only counts while a request is outstanding
  assign ack_take = (state == REQ) && bus.int_ack;

  // Clear vector for the source being acknowledged
  always_comb begin
    ack_clr = 4'b0000;
    if (ack_take) ack_clr[int_data_q] = 1'b1;
  end

  // Pending latch: a fresh edge on the same bit as the acknowledge must survive,
  // so the set term is OR-ed in after the clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= '0;
    end else begin
      pending_q <= (pending_q & ~ack_clr) | irq_rise;
    end
  end

  // Mask register, writable in every state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask_q <= MASK_RESET;
    end else if (bus.mask_we) begin
      mask_q <= bus.mask_wdata;
    end
  end

  // Request/service sequencing with registered INT, vector, epc and in_service
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      int_q        <= 1'b0;
      int_data_q   <= 2'd0;
      epc_q        <= 32'd0;
      in_service_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // The vector is frozen here; later mask writes or new edges cannot move it
          if (|eligible) begin
            int_data_q <= pick_id;
            int_q      <= 1'b1;
            state      <= REQ;
          end
        end
        REQ: begin
          if (bus.int_ack) begin
            epc_q        <= bus.epc_in;
            int_q        <= 1'b0;
            in_service_q <= 1'b1;
            state        <= SERVICE;
          end
        end
        SERVICE: begin
          // No nesting: INT stays low until the handler returns
          if (bus.int_ret) begin
            in_service_q <= 1'b0;
            state        <= IDLE;
          end
        end
        default: begin
          int_q        <= 1'b0;
          in_service_q <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

  assign bus.INT        = int_q;
  assign bus.INT_data   = int_data_q;
  assign bus.epc        = epc_q;
  assign bus.in_service = in_service_q;
  assign bus.pending    = pending_q;
  assign bus.irq_mask   = mask_q;

endmodule

// File: tb/tb_int_ctrl.sv
// tb/tb_int_ctrl.sv - self-checking bench for int_ctrl with a behavioural reference model
module tb_int_ctrl;

  localparam int S = 2;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  int_ctrl_if bus ();

  int_ctrl #(
    .SYNC_STAGES(S),
    .MASK_RESET (4'hF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: m_hist[k] is the irq_in value sampled k+1 edges ago.
  // Mode 0 = waiting for eligible work, 1 = request outstanding, 2 = handler running.
  logic [3:0]  m_hist [$];
  int          m_mode;
  logic [1:0]  m_id;
  logic [31:0] m_epc;
  logic [3:0]  m_pend;
  logic [3:0]  m_mask;

  task automatic model_reset();
    m_hist = {};
    for (int i = 0; i <= S; i++) m_hist.push_back(4'h0);
    m_mode = 0;
    m_id   = 2'd0;
    m_epc  = 32'd0;
    m_pend = 4'h0;
    m_mask = 4'hF;
  endtask

  function automatic logic [1:0] lowest(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return 2'(i);
    return 2'd0;
  endfunction

  // Advance model and DUT by one clock; ends at posedge + 1
  task automatic step();
    logic [3:0] seen_now, seen_before, rise, clr, elig;
    seen_now    = m_hist[S-1];
    seen_before = m_hist[S];
    rise        = seen_now & ~seen_before;
    clr         = (m_mode == 1 && bus.int_ack) ? (4'b0001 << m_id) : 4'b0000;
    elig        = m_pend & m_mask;
    if (m_mode == 0) begin
      if (elig != 4'h0) begin
        m_id   = lowest(elig);
        m_mode = 1;
      end
    end else if (m_mode == 1) begin
      if (bus.int_ack) begin
        m_epc  = bus.epc_in;
        m_mode = 2;
      end
    end else begin
      if (bus.int_ret) m_mode = 0;
    end
    m_pend = (m_pend & ~clr) | rise;
    if (bus.mask_we) m_mask = bus.mask_wdata;
    m_hist.push_front(bus.irq_in);
    void'(m_hist.pop_back());
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic idle_inputs();
    bus.mask_we    = 1'b0;
    bus.mask_wdata = 4'h0;
    bus.int_ack    = 1'b0;
    bus.int_ret    = 1'b0;
    bus.epc_in     = 32'h0;
  endtask

  // Assert reset between edges, leave it high across one edge, release at posedge + 1
  task automatic assert_reset();
    rst = 1'b1;
    #2;
    model_reset();
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bus.irq_in = 4'h0;
    idle_inputs();
    assert_reset();
    n_tests++; if (bus.INT !== 1'b0) begin n_fail++; $display("FAIL reset_INT: got %b want 0", bus.INT); end
    n_tests++; if (bus.INT_data !== 2'd0) begin n_fail++; $display("FAIL reset_INT_data: got %0d want 0", bus.INT_data); end
    n_tests++; if (bus.epc !== 32'h0) begin n_fail++; $display("FAIL reset_epc: got %h want 0", bus.epc); end
    n_tests++; if (bus.in_service !== 1'b0) begin n_fail++; $display("FAIL reset_in_service: got %b want 0", bus.in_service); end
    n_tests++; if (bus.pending !== 4'h0) begin n_fail++; $display("FAIL reset_pending: got %b want 0000", bus.pending); end
    n_tests++; if (bus.irq_mask !== 4'hF) begin n_fail++; $display("FAIL reset_irq_mask: got %h want F", bus.irq_mask); end
    release_reset();
  endtask

  task automatic test_latency();
    assert_reset();
    release_reset();
    bus.irq_in = 4'b0100;
    steps(3);
    n_tests++; if (bus.INT !== 1'b0) begin n_fail++; $display("FAIL lat_INT_edge3: got %b want 0", bus.INT); end
    n_tests++; if (bus.pending !== 4'b0100) begin n_fail++; $display("FAIL lat_pending_edge3: got %b want 0100", bus.pending); end
    step();
    n_tests++; if (bus.INT !== 1'b1) begin n_fail++; $display("FAIL lat_INT_edge4: got %b want 1", bus.INT); end
    n_tests++; if (bus.INT_data !== 2'd2) begin n_fail++; $display("FAIL lat_INT_data_edge4: got %0d want 2", bus.INT_data); end
    steps(6);
    n_tests++; if (bus.INT !== 1'b1) begin n_fail++; $display("FAIL lat_INT_hold: got %b want 1", bus.INT); end
    n_tests++; if (bus.INT_data !== 2'd2) begin n_fail++; $display("FAIL lat_INT_data_hold: got %0d want 2", bus.INT_data); end
  endtask

  task automatic test_priority_ack_ret();
    assert_reset();
    bus.irq_in = 4'h0;
    release_reset();
    bus.irq_in = 4'b1010;
    steps(4);
    n_tests++; if (bus.INT !== 1'b1) begin n_fail++; $display("FAIL pri_INT: got %b want 1", bus.INT); end
    n_tests++; if (bus.INT_data !== 2'd1) begin n_fail++; $display("FAIL pri_INT_data: got %0d want 1", bus.INT_data); end
    bus.int_ack = 1'b1;
    bus.epc_in  = 32'h0000_0124;
    step();
    idle_inputs();
    n_tests++; if (bus.epc !== 32'h124) begin n_fail++; $display("FAIL ack_epc: got %h want 00000124", bus.epc); end
    n_tests++; if (bus.pending !== 4'b1000) begin n_fail++; $display("FAIL ack_pending: got %b want 1000", bus.pending); end
    n_tests++; if (bus.INT !== 1'b0) begin n_fail++; $display("FAIL ack_INT: got %b want 0", bus.INT); end
    n_tests++; if (bus.in_service !== 1'b1) begin n_fail++; $display("FAIL ack_in_service: got %b want 1", bus.in_service); end
    bus.int_ret = 1'b1;
    step();
    idle_inputs();
    n_tests++; if (bus.INT !== 1'b0 || bus.in_service !== 1'b0) begin n_fail++; $display("FAIL ret_idle: got INT=%b in_service=%b want 0 0", bus.INT, bus.in_service); end
    step();
    n_tests++; if (bus.INT !== 1'b1) begin n_fail++; $display("FAIL ret_INT: got %b want 1", bus.INT); end
    n_tests++; if (bus.INT_data !== 2'd3) begin n_fail++; $display("FAIL ret_INT_data: got %0d want 3", bus.INT_data); end
  endtask

  task automatic test_mask_and_service();
    assert_reset();
    bus.irq_in = 4'h0;
    release_reset();
    bus.mask_we    = 1'b1;
    bus.mask_wdata = 4'b1110;
    step();
    idle_inputs();
    bus.irq_in = 4'b0001;
    steps(5);
    n_tests++; if (bus.pending !== 4'b0001) begin n_fail++; $display("FAIL mask_pending: got %b want 0001", bus.pending); end
    n_tests++; if (bus.INT !== 1'b0) begin n_fail++; $display("FAIL mask_INT_gated: got %b want 0", bus.INT); end
    bus.mask_we    = 1'b1;
    bus.mask_wdata = 4'hF;
    step();
    idle_inputs();
    step();
    n_tests++; if (bus.INT !== 1'b1) begin n_fail++; $display("FAIL unmask_INT: got %b want 1", bus.INT); end
    n_tests++; if (bus.INT_data !== 2'd0) begin n_fail++; $display("FAIL unmask_INT_data: got %0d want 0", bus.INT_data); end
    bus.int_ack = 1'b1;
    bus.epc_in  = 32'h0000_0055;
    step();
    idle_inputs();
    bus.irq_in = 4'b0101;
    steps(3);
    n_tests++; if (bus.pending !== 4'b0100) begin n_fail++; $display("FAIL svc_pending: got %b want 0100", bus.pending); end
    n_tests++; if (bus.INT !== 1'b0) begin n_fail++; $display("FAIL svc_INT: got %b want 0", bus.INT); end
    bus.int_ack = 1'b1;
    bus.epc_in  = 32'hDEAD_BEEF;
    steps(2);
    idle_inputs();
    n_tests++; if (bus.epc !== 32'h55) begin n_fail++; $display("FAIL svc_epc_kept: got %h want 00000055", bus.epc); end
    n_tests++; if (bus.in_service !== 1'b1) begin n_fail++; $display("FAIL svc_in_service: got %b want 1", bus.in_service); end
    n_tests++; if (bus.INT !== 1'b0) begin n_fail++; $display("FAIL svc_INT_after_ack: got %b want 0", bus.INT); end
  endtask

  task automatic test_reset_mid_req();
    assert_reset();
    bus.irq_in = 4'h0;
    release_reset();
    bus.irq_in = 4'b0001;
    steps(4);
    bus.int_ack = 1'b1;
    bus.epc_in  = 32'h0000_ABCD;
    step();
    idle_inputs();
    bus.irq_in = 4'b0000;
    steps(3);
    bus.irq_in = 4'b0011;
    steps(3);
    bus.int_ret = 1'b1;
    step();
    idle_inputs();
    step();
    n_tests++; if (bus.INT !== 1'b1 || bus.pending !== 4'b0011) begin n_fail++; $display("FAIL rst_setup: got INT=%b pending=%b want 1 0011", bus.INT, bus.pending); end
    n_tests++; if (bus.epc !== 32'hABCD) begin n_fail++; $display("FAIL rst_setup_epc: got %h want 0000abcd", bus.epc); end
    bus.irq_in = 4'h0;
    assert_reset();
    n_tests++; if (bus.INT !== 1'b0 || bus.INT_data !== 2'd0) begin n_fail++; $display("FAIL rst_mid_INT: got INT=%b data=%0d want 0 0", bus.INT, bus.INT_data); end
    n_tests++; if (bus.pending !== 4'h0 || bus.epc !== 32'h0) begin n_fail++; $display("FAIL rst_mid_state: got pending=%b epc=%h want 0000 0", bus.pending, bus.epc); end
    n_tests++; if (bus.in_service !== 1'b0 || bus.irq_mask !== 4'hF) begin n_fail++; $display("FAIL rst_mid_misc: got in_service=%b mask=%h want 0 F", bus.in_service, bus.irq_mask); end
    release_reset();
    steps(8);
    n_tests++; if (bus.INT !== 1'b0 || bus.pending !== 4'h0) begin n_fail++; $display("FAIL rst_quiet: got INT=%b pending=%b want 0 0000", bus.INT, bus.pending); end
    bus.irq_in = 4'b0100;
    steps(4);
    n_tests++; if (bus.INT !== 1'b1 || bus.INT_data !== 2'd2) begin n_fail++; $display("FAIL rst_new_edge: got INT=%b data=%0d want 1 2", bus.INT, bus.INT_data); end
  endtask

  task automatic test_ack_set_collision();
    assert_reset();
    bus.irq_in = 4'h0;
    release_reset();
    bus.irq_in = 4'b0010;
    steps(4);
    n_tests++; if (bus.INT !== 1'b1 || bus.INT_data !== 2'd1) begin n_fail++; $display("FAIL col_setup: got INT=%b data=%0d want 1 1", bus.INT, bus.INT_data); end
    bus.irq_in = 4'b0000;
    steps(3);
    bus.irq_in = 4'b0010;
    steps(2);
    bus.int_ack = 1'b1;
    bus.epc_in  = 32'h0000_0039;
    step();
    idle_inputs();
    n_tests++; if (bus.pending[1] !== 1'b1) begin n_fail++; $display("FAIL col_pending1: got %b want 1", bus.pending[1]); end
    n_tests++; if (bus.in_service !== 1'b1 || bus.epc !== 32'h39) begin n_fail++; $display("FAIL col_service: got in_service=%b epc=%h want 1 00000039", bus.in_service, bus.epc); end
    bus.int_ret = 1'b1;
    step();
    idle_inputs();
    step();
    n_tests++; if (bus.INT !== 1'b1 || bus.INT_data !== 2'd1) begin n_fail++; $display("FAIL col_rerequest: got INT=%b data=%0d want 1 1", bus.INT, bus.INT_data); end
  endtask

  task automatic test_random();
    assert_reset();
    bus.irq_in = 4'h0;
    idle_inputs();
    release_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 5) == 0) bus.irq_in = bus.irq_in ^ 4'($urandom_range(0, 15));
      bus.mask_we    = ($urandom_range(0, 15) == 0);
      bus.mask_wdata = 4'($urandom_range(0, 15));
      bus.int_ack    = ($urandom_range(0, 3) == 0);
      bus.int_ret    = ($urandom_range(0, 5) == 0);
      bus.epc_in     = $urandom;
      step();
      n_tests++; if (bus.INT !== (m_mode == 1)) begin n_fail++; $display("FAIL rnd_INT c=%0d: got %b want %b", c, bus.INT, (m_mode == 1)); end
      n_tests++; if (bus.INT_data !== m_id) begin n_fail++; $display("FAIL rnd_INT_data c=%0d: got %0d want %0d", c, bus.INT_data, m_id); end
      n_tests++; if (bus.epc !== m_epc) begin n_fail++; $display("FAIL rnd_epc c=%0d: got %h want %h", c, bus.epc, m_epc); end
      n_tests++; if (bus.in_service !== (m_mode == 2)) begin n_fail++; $display("FAIL rnd_in_service c=%0d: got %b want %b", c, bus.in_service, (m_mode == 2)); end
      n_tests++; if (bus.pending !== m_pend) begin n_fail++; $display("FAIL rnd_pending c=%0d: got %b want %b", c, bus.pending, m_pend); end
      n_tests++; if (bus.irq_mask !== m_mask) begin n_fail++; $display("FAIL rnd_irq_mask c=%0d: got %h want %h", c, bus.irq_mask, m_mask); end
    end
    idle_inputs();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    bus.irq_in = 4'h0;
    idle_inputs();
    model_reset();
    @(posedge clk);
    #1;
    test_reset();
    test_latency();
    test_priority_ack_ret();
    test_mask_and_service();
    test_reset_mid_req();
    test_ack_set_collision();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/int_ctrl.md
INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 Parameter SYNC_STAGES, default 2, SHALL set the number of synchronizer flops per request line (legal range 2-4).
REQ-002 Parameter MASK_RESET, default 4'hF, SHALL set the reset value of irq_mask (1 = enabled).
REQ-003 clk  in  1  system clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 irq_in  in  4  raw external interrupt requests, asynchronous to clk, active-high.
REQ-006 mask_we  in  1  mask write strobe.
REQ-007 mask_wdata  in  4  new mask value, written when mask_we=1.
REQ-008 int_ack  in  1  one-cycle acknowledge from the next-PC stage when the vector has been loaded.
REQ-009 int_ret  in  1  one-cycle return-from-interrupt pulse from decode.
REQ-010 epc_in  in  32  return address offered by the next-PC stage, valid with int_ack.
REQ-011 INT  out  1  registered interrupt request to the next-PC stage.
REQ-012 INT_data  out  2  registered source id (vector select), valid while INT=1.
REQ-013 epc  out  32  saved return address.
REQ-014 in_service  out  1  handler running.
REQ-015 pending  out  4  latched pending requests.
REQ-016 irq_mask  out  4  current enable mask.

Function
REQ-017 Each irq_in bit SHALL pass through SYNC_STAGES flops; an edge detector SHALL compare the synchronized value with a one-cycle-delayed copy.
REQ-018 A synchronized 0->1 transition on bit i SHALL set pending[i] on the following edge; level-held inputs SHALL NOT re-set pending.
REQ-019 pending SHALL be set regardless of mask; masking SHALL only gate selection.
REQ-020 FSM states SHALL be IDLE, REQ, SERVICE.
REQ-021 IDLE: if (pending & irq_mask) != 0, SHALL latch the lowest-index eligible bit into INT_data and enter REQ; bit 0 is highest priority.
REQ-022 REQ: INT SHALL be 1 and INT_data SHALL hold stable; mask writes or new pending bits SHALL NOT change INT_data or withdraw the request.
REQ-023 REQ with int_ack=1: SHALL clear pending[INT_data], load epc from epc_in, enter SERVICE; INT SHALL be 0 from the next cycle.
REQ-024 SERVICE: INT SHALL stay 0 (no nesting); new edges SHALL still set pending; int_ret=1 SHALL return to IDLE.
REQ-025 int_ack outside REQ and int_ret outside SERVICE SHALL be ignored.
REQ-026 New edge on bit i in the same cycle pending[i] is cleared by int_ack: set SHALL win.
REQ-027 mask_we SHALL update irq_mask on the next edge in any state.
REQ-028 in_service SHALL equal (state == SERVICE), registered.
REQ-029 Latency: irq_in high, stable from before edge 1 -> INT=1 after edge SYNC_STAGES+2 (4 edges at default); int_ret in SERVICE with eligible pending -> INT=1 two edges later (IDLE, then REQ).
REQ-030 epc SHALL change only on an accepted int_ack.

Reset
REQ-031 rst=1 SHALL immediately force: synchronizer and edge flops 0, pending=0, state IDLE, INT=0, INT_data=0, epc=0, in_service=0, irq_mask=MASK_RESET.
REQ-032 Reset asserted in REQ or SERVICE SHALL discard the request, pending bits and epc without requiring int_ack or int_ret.
REQ-033 After rst deasserts, an irq_in already high SHALL NOT be seen as an edge until it drops and rises again... except that the first synchronized rise from reset value 0 SHALL count as an edge.

Verification
REQ-034 irq_in=4'b0100 held, mask=F -> INT=1, INT_data=2 after edge 4; hold without ack -> INT stays 1, INT_data=2.
REQ-035 irq_in 4'b1010 rising together -> INT_data=1; int_ack with epc_in=32'h0000_0124 -> epc=32'h124, pending=4'b1000, INT=0, in_service=1; int_ret -> INT=1, INT_data=3 two edges later.
REQ-036 mask=4'b1110, edge on bit 0 -> pending=4'b0001, INT=0; write mask=F -> INT=1, INT_data=0.
REQ-037 In SERVICE, edge on bit 2 -> pending[2]=1, INT=0; int_ack pulses ignored; epc unchanged.
REQ-038 rst pulse mid-REQ with pending=4'b0011 -> all outputs at reset values immediately, irq_mask=F, no INT until a new edge.
REQ-039 int_ack for id 1 in the same cycle as a new synchronized rise on bit 1 -> pending[1]=1 after the edge, SERVICE entered.
